// File: rtl/cnn_operand_loader_pkg.sv
// Shared types and operand geometry for the CNN operand loader.
package cnn_loader_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    RESULT  = 2'd2
  } ld_state_e;

  localparam int IMG_W         = 64;
  localparam int KER_W         = 72;
  localparam int MAP_W         = 9;
  localparam int LAST_IMG_BEAT = 7;
  localparam int LAST_BEAT     = 16;

endpackage

// File: rtl/cnn_operand_loader_if.sv
// Byte-stream input and result handshake bundle of the operand loader.
// kernel_reuse exists only when CNN_LOADER_KERNEL_REUSE_EN is defined.
interface cnn_operand_loader_if;
  import cnn_loader_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             in_sof;
  logic             res_valid;
  logic             res_ready;
  logic [MAP_W-1:0] res_map;
`ifdef CNN_LOADER_KERNEL_REUSE_EN
  logic             kernel_reuse;
`endif

  modport master (
`ifdef CNN_LOADER_KERNEL_REUSE_EN
    output kernel_reuse,
`endif
    output in_valid, in_data, in_sof, res_ready,
    input  in_ready, res_valid, res_map
  );

  modport slave (
`ifdef CNN_LOADER_KERNEL_REUSE_EN
    input  kernel_reuse,
`endif
    input  in_valid, in_data, in_sof, res_ready,
    output in_ready, res_valid, res_map
  );

endinterface

// File: rtl/cnn_operand_loader_accel.sv
// cnn_accelerator: 8x8 binary image convolved with signed 8-bit 3x3 taps (6x6 valid),
// each output bit is a 2x2 max-pool of (sum > 0); bit 8 is pooled window (0,0).
module cnn_accelerator (
  input  logic [63:0] image,
  input  logic [71:0] kernel,
  output logic [8:0]  output_map
);

  logic signed [11:0] acc;
  logic               hit;

  always_comb begin
    output_map = '0;
    acc        = '0;
    hit        = 1'b0;
    for (int p = 0; p < 3; p++) begin
      for (int q = 0; q < 3; q++) begin
        hit = 1'b0;
        for (int d = 0; d < 4; d++) begin
          acc = '0;
          // image row r occupies byte 7-r; column c is bit 7-c within that byte
          for (int t = 0; t < 9; t++) begin
            if (image[63 - 8*(2*p + d/2 + t/3) - (2*q + d%2 + t%3)])
              acc = acc + {{4{kernel[71-8*t]}}, kernel[71-8*t -: 8]};
          end
          if (acc > 12'sd0) hit = 1'b1;
        end
        output_map[8 - 3*p - q] = hit;
      end
    end
  end

endmodule

// File: rtl/cnn_operand_loader.sv
// Byte-stream loader feeding cnn_accelerator, with one-cycle settle and held result.
// Optional CNN_LOADER_KERNEL_REUSE_EN: 8-beat frames that keep the previous kernel.
module cnn_operand_loader
  import cnn_loader_pkg::*;
#(
  parameter int IMG_BEATS = 8,
  parameter int KER_BEATS = 9,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cnn_operand_loader_if.slave  bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     frames_done
);

  localparam int NBEATS = IMG_BEATS + KER_BEATS;
  localparam int BW     = $clog2(NBEATS + 1);
  localparam logic [BW-1:0] LAST_IMG = BW'(IMG_BEATS - 1);
  localparam logic [BW-1:0] LAST_B   = BW'(NBEATS - 1);

  ld_state_e        state, state_nx;
  logic [BW-1:0]    cnt, cnt_nx, beat;
  logic [IMG_W-1:0] img_q;
  logic [KER_W-1:0] ker_q;
  logic [MAP_W-1:0] map_w, res_map_q;
  logic             res_valid_q, accept, last_beat, reuse_now;
  logic [CNT_W-1:0] done_q;

  assign bus.in_ready  = (state == LOAD);
  assign bus.res_valid = res_valid_q;
  assign bus.res_map   = res_map_q;
  assign frames_done   = done_q;
  assign busy          = !(state == LOAD && cnt == '0);

  assign accept = bus.in_valid && bus.in_ready;
  // start-of-frame always restarts at beat 0, abandoning any partial frame
  assign beat   = bus.in_sof ? '0 : cnt;

`ifdef CNN_LOADER_KERNEL_REUSE_EN
  logic reuse_q;
  assign reuse_now = (beat == '0) ? bus.kernel_reuse : reuse_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      reuse_q <= 1'b0;
    else if (accept && beat == '0)   reuse_q <= bus.kernel_reuse;
  end
`else
  assign reuse_now = 1'b0;
`endif

  assign last_beat = (beat == LAST_B) || (reuse_now && beat == LAST_IMG);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      LOAD: if (accept) begin
        cnt_nx = beat + 1'b1;
        if (last_beat) state_nx = COMPUTE;
      end
      COMPUTE: state_nx = RESULT;
      RESULT: if (bus.res_ready) begin
        state_nx = LOAD;
        cnt_nx   = '0;
      end
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_q       <= '0;
      ker_q       <= '0;
      res_map_q   <= '0;
      res_valid_q <= 1'b0;
      done_q      <= '0;
    end else begin
      if (accept) begin
        for (int r = 0; r < IMG_W/8; r++)
          if (beat == BW'(r)) img_q[IMG_W-1-8*r -: 8] <= bus.in_data;
        for (int t = 0; t < KER_W/8; t++)
          if (beat == BW'(IMG_BEATS + t)) ker_q[KER_W-1-8*t -: 8] <= bus.in_data;
      end
      if (state == COMPUTE) begin
        res_map_q   <= map_w;
        res_valid_q <= 1'b1;
      end
      if (state == RESULT && bus.res_ready) begin
        res_valid_q <= 1'b0;
        done_q      <= done_q + 1'b1;
      end
    end
  end

  cnn_accelerator u_accel (
    .image      (img_q),
    .kernel     (ker_q),
    .output_map (map_w)
  );

endmodule

// File: tb/tb_cnn_operand_loader.sv
// Directed scoreboard bench for cnn_operand_loader; expected maps from a local conv/pool model.
module tb_cnn_operand_loader;
  import cnn_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        busy;
  logic [15:0] frames_done;

  cnn_operand_loader_if bus ();

  cnn_operand_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .busy        (busy),
    .frames_done (frames_done)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [8:0]  exp_q[$];
  logic [71:0] cur_ker = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] model(input logic [63:0] img, input logic [71:0] ker);
    int conv [6][6];
    int w [3][3];
    logic [8:0] m;
    for (int t = 0; t < 9; t++) w[t/3][t%3] = int'($signed(ker[71-8*t -: 8]));
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) begin
        conv[r][c] = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            if (img[63 - 8*(r+i) - (c+j)]) conv[r][c] += w[i][j];
      end
    m = '0;
    for (int p = 0; p < 3; p++)
      for (int q = 0; q < 3; q++)
        for (int d = 0; d < 4; d++)
          if (conv[2*p + d/2][2*q + d%2] > 0) m[8 - 3*p - q] = 1'b1;
    return m;
  endfunction

  task automatic send_beat(input logic [7:0] d, input logic s);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sof   = s;
    while (!bus.in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("beat_accept_bound", 128'(n < 64), 128'(1));
    @(posedge clk);
    @(negedge clk);
    bus.in_sof = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] img, input logic [71:0] ker, input logic reuse);
    if (!reuse) cur_ker = ker;
    exp_q.push_back(model(img, cur_ker));
`ifdef CNN_LOADER_KERNEL_REUSE_EN
    bus.kernel_reuse = reuse;
`endif
    for (int r = 0; r < 8; r++) send_beat(img[63-8*r -: 8], 1'b0);
    if (!reuse)
      for (int t = 0; t < 9; t++) send_beat(ker[71-8*t -: 8], 1'b0);
    bus.in_valid = 1'b0;
  endtask

  // called at the falling edge right after the last beat was taken
  task automatic latency(input string tag);
    check({tag, "_compute_ready"}, 128'(bus.in_ready), 128'(0));
    check({tag, "_compute_valid"}, 128'(bus.res_valid), 128'(0));
    @(negedge clk);
    check({tag, "_res_valid_2cyc"}, 128'(bus.res_valid), 128'(1));
  endtask

  task automatic get_result(input string tag);
    int n = 0;
    logic [8:0] e;
    while (!bus.res_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_wait_bound"}, 128'(n < 64), 128'(1));
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 128'(0), 128'(1));
    end else begin
      e = exp_q.pop_front();
      check({tag, "_res_map"}, 128'(bus.res_map), 128'(e));
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check({tag, "_valid_drop"}, 128'(bus.res_valid), 128'(0));
    check({tag, "_ready_back"}, 128'(bus.in_ready), 128'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] img;
    logic [71:0] ker;
    logic [8:0]  held;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_sof    = 1'b0;
    bus.res_ready = 1'b0;
`ifdef CNN_LOADER_KERNEL_REUSE_EN
    bus.kernel_reuse = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 128'(bus.in_ready), 128'(1));
    check("rst_res_valid", 128'(bus.res_valid), 128'(0));
    check("rst_res_map", 128'(bus.res_map), 128'(0));
    check("rst_frames_done", 128'(frames_done), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // full frame
    send_frame({8{8'hF0}}, 72'h010100808100808101, 1'b0);
    check("full_image", 128'(dut.img_q), 128'(64'hF0F0F0F0F0F0F0F0));
    check("full_kernel", 128'(dut.ker_q), 128'(72'h010100808100808101));
    latency("full");
    get_result("full");
    check("full_frames_done", 128'(frames_done), 128'(1));

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst2_frames_done", 128'(frames_done), 128'(0));

    // backpressure with the source still offering a byte
    send_frame({8{8'hAA}}, {9{8'h55}}, 1'b0);
    latency("bp");
    held = exp_q[0];
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", 128'(bus.in_ready), 128'(0));
      check("bp_res_map_held", 128'(bus.res_map), 128'(held));
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    get_result("bp");
    check("bp_frames_done", 128'(frames_done), 128'(1));

    // resync: sof on 5th beat restarts the frame
    img = 64'h3CC3_1881_7E00_FF5A;
    ker = 72'h7F_80_01_FF_10_F0_22_DD_05;
    cur_ker = ker;
    exp_q.push_back(model(img, ker));
    for (int i = 0; i < 4; i++) send_beat(8'(8'h11 * (i + 1)), 1'b0);
    send_beat(img[63:56], 1'b1);
    check("sync_row0", 128'(dut.img_q[63:56]), 128'(8'h3C));
    check("sync_busy", 128'(busy), 128'(1));
    for (int r = 1; r < 8; r++) send_beat(img[63-8*r -: 8], 1'b0);
    for (int t = 0; t < 8; t++) send_beat(ker[71-8*t -: 8], 1'b0);
    check("sync_still_loading", 128'(bus.in_ready), 128'(1));
    check("sync_no_early_valid", 128'(bus.res_valid), 128'(0));
    send_beat(ker[7:0], 1'b0);
    bus.in_valid = 1'b0;
    latency("sync");
    get_result("sync");
    check("sync_frames_done", 128'(frames_done), 128'(2));

    // reset mid-frame
    for (int i = 0; i < 10; i++) send_beat(8'($urandom()), 1'b0);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_image", 128'(dut.img_q), 128'(0));
    check("mid_rst_kernel", 128'(dut.ker_q), 128'(0));
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_ready", 128'(bus.in_ready), 128'(1));
    check("mid_rst_frames", 128'(frames_done), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    img = {$urandom(), $urandom()};
    ker = {8'($urandom()), $urandom(), $urandom()};
    send_frame(img, ker, 1'b0);
    check("fresh_image", 128'(dut.img_q), 128'(img));
    check("fresh_kernel", 128'(dut.ker_q), 128'(ker));
    latency("fresh");
    get_result("fresh");
    check("fresh_frames_done", 128'(frames_done), 128'(1));

`ifdef CNN_LOADER_KERNEL_REUSE_EN
    img = 64'h00FF_00FF_0F0F_F0F0;
    send_frame(img, 72'h0, 1'b1);
    check("reuse_image", 128'(dut.img_q), 128'(img));
    check("reuse_kernel", 128'(dut.ker_q), 128'(cur_ker));
    latency("reuse");
    get_result("reuse");
    check("reuse_frames_done", 128'(frames_done), 128'(2));
    bus.kernel_reuse = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
